// File: rtl/fetch_unit_r32i_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Imported by the top level, the instruction buffer users and the bench.
package fetchpkgR32I;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        WAIT    = 2'b01,
        DISCARD = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_INS    = 32'h0000_0013;
    localparam int          INS_ALIGN  = 2;
    localparam logic [31:0] ALIGN_MASK = ~32'((1 << INS_ALIGN) - 1);

    // One buffered fetch result: the raw word and the address it came from.
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] addr;
    } ins_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_r32i_instr_buffer.sv
// Synchronous FIFO of fetched {ins, addr} entries; head is read straight from storage.
// A write is visible at the head one cycle later; push into a full buffer is taken only with a pop.
module instr_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]    CNT_FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_FULL);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fetch_unit_r32i.sv
// RV32I fetch stage: PC, single-outstanding imem handshake, buffered delivery to the decoder.
// Response at edge N is visible in cycle N+1; requests stop while the buffer is full.
module fetch_unit_r32i
    import fetchpkgR32I::*;
#(
    parameter int          dataW     = 32,
    parameter logic [31:0] resetAddr = 32'h0000_0000,
    parameter int          bufDepth  = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imemReq,
    output logic [dataW-1:0] imemAddr,
    input  logic             imemGnt,
    input  logic [dataW-1:0] imemRdata,
    input  logic             imemRvalid,
    output logic [dataW-1:0] rawIns,
    output logic [dataW-1:0] insAddr,
    output logic             insValid,
    input  logic             insReady,
    input  logic             redirect,
    input  logic [dataW-1:0] redirectAddr
);

    localparam int               CW        = $clog2(bufDepth) + 1;
    localparam logic [dataW-1:0] INS_BYTES = dataW'(4);

    fetch_state_t     state_q, state_d;
    logic [dataW-1:0] pc_q, pc_d;
    logic [dataW-1:0] pend_addr_q, pend_addr_d;

    logic             req_ok;
    logic             gnt_acc;
    logic             buf_push, buf_pop;
    logic             buf_empty, buf_full;
    logic [CW-1:0]    buf_count;
    ins_entry_t       push_entry, head_entry;

    // Reset masks the request so the port reads idle while reset is held.
    assign req_ok   = (state_q == FETCH) && !buf_full && !redirect && !reset;
    assign gnt_acc  = req_ok && imemGnt;
    assign imemReq  = req_ok;
    assign imemAddr = pc_q;

    assign buf_push   = (state_q == WAIT) && imemRvalid && !redirect;
    assign push_entry = '{ins: imemRdata, addr: pend_addr_q};

    assign insValid = (buf_count != '0);
    assign buf_pop  = insValid && insReady;
    assign rawIns   = buf_empty ? NOP_INS : head_entry.ins;
    assign insAddr  = buf_empty ? '0 : head_entry.addr;

    instr_buffer #(
        .WIDTH ($bits(ins_entry_t)),
        .DEPTH (bufDepth)
    ) u_instr_buffer (
        .clk_i      (clk),
        .rst_i      (reset),
        .push_i     (buf_push),
        .push_dat_i (push_entry),
        .pop_i      (buf_pop),
        .flush_i    (redirect),
        .head_dat_o (head_entry),
        .count_o    (buf_count),
        .empty_o    (buf_empty),
        .full_o     (buf_full)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        if (redirect) begin
            pc_d = align_word(redirectAddr);
            // A response still in flight must be swallowed before fetching the target.
            case (state_q)
                WAIT, DISCARD: state_d = imemRvalid ? FETCH : DISCARD;
                default:       state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (gnt_acc) begin
                        pc_d        = pc_q + INS_BYTES;
                        pend_addr_d = pc_q;
                        state_d     = WAIT;
                    end
                end
                WAIT, DISCARD: begin
                    if (imemRvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= resetAddr;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
        end
    end

endmodule
